// File: rtl/dpram_fifo_ctrl.sv
// Valid/ready FIFO controller in front of a dual-port RAM with registered reads.
// Port 0 writes, port 1 reads; a 2-entry output buffer hides read latency.
module dpram_fifo_ctrl #(
  parameter int unsigned DATA_N = 32,
  parameter int unsigned SIZE   = 128,
  parameter int unsigned CW     = $clog2(SIZE + 3),
  localparam int unsigned AW    = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_N-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_N-1:0] rd_data,
  input  logic              rd_ready,
  output logic              ram_we0,
  output logic [AW-1:0]     ram_addr0,
  output logic [DATA_N-1:0] ram_w0_data,
  output logic              ram_we1,
  output logic [AW-1:0]     ram_addr1,
  output logic [DATA_N-1:0] ram_w1_data,
  input  logic [DATA_N-1:0] ram_r1_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  localparam logic [AW:0] RAM_FULL = (AW + 1)'(SIZE);

  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       ram_cnt_q, ram_cnt_d;
  logic              inflight_q, inflight_d;
  logic [DATA_N-1:0] ob_mem_q [2];
  logic [DATA_N-1:0] ob_mem_d [2];
  logic              ob_head_q, ob_head_d;
  logic              ob_tail_q, ob_tail_d;
  logic [1:0]        ob_cnt_q, ob_cnt_d;
  logic [DATA_N-1:0] rd_data_q, rd_data_d;

  logic       push, pop, issue;
  logic [2:0] ob_occ;

  assign wr_ready    = rst_n && (ram_cnt_q < RAM_FULL);
  assign rd_valid    = (ob_cnt_q != 2'd0);
  assign rd_data     = rd_data_q;
  assign push        = wr_valid && wr_ready;
  assign pop         = rd_valid && rd_ready;

  // Buffer slots already claimed (held + returning) must leave room for the new read.
  assign ob_occ      = {1'b0, ob_cnt_q} + {2'b00, inflight_q};
  assign issue       = (ram_cnt_q != '0) && (ob_occ < (3'd2 + {2'b00, pop}));

  assign ram_we0     = push;
  assign ram_addr0   = wptr_q;
  assign ram_w0_data = wr_data;
  assign ram_we1     = 1'b0;
  assign ram_addr1   = rptr_q;
  assign ram_w1_data = '0;

  assign count = CW'(ram_cnt_q) + CW'(inflight_q) + CW'(ob_cnt_q);
  assign full  = (ram_cnt_q == RAM_FULL);
  assign empty = (count == '0);

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    ob_mem_d   = ob_mem_q;
    ob_head_d  = ob_head_q;
    ob_tail_d  = ob_tail_q;
    inflight_d = issue;
    ram_cnt_d  = ram_cnt_q + (AW + 1)'(push) - (AW + 1)'(issue);
    ob_cnt_d   = ob_cnt_q + 2'(inflight_q) - 2'(pop);

    if (push)  wptr_d = wptr_q + AW'(1);
    if (issue) rptr_d = rptr_q + AW'(1);
    if (pop)   ob_head_d = ~ob_head_q;
    if (inflight_q) begin
      ob_mem_d[ob_tail_q] = ram_r1_data;
      ob_tail_d           = ~ob_tail_q;
    end

    // rd_data is the registered head; it keeps its last value once the buffer drains.
    rd_data_d = (ob_cnt_d != 2'd0) ? ob_mem_d[ob_head_d] : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      ob_mem_q   <= '{default: '0};
      ob_head_q  <= 1'b0;
      ob_tail_q  <= 1'b0;
      ob_cnt_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      ob_mem_q   <= ob_mem_d;
      ob_head_q  <= ob_head_d;
      ob_tail_q  <= ob_tail_d;
      ob_cnt_q   <= ob_cnt_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: SIZE=128 and SIZE=4 instances, each with a behavioural RAM.
module tb_dpram_fifo_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: SIZE=128 ----------------
  logic        a_wv = 1'b0, a_rr = 1'b0;
  logic [31:0] a_wd = '0;
  logic        a_wr_ready, a_rd_valid, a_we0, a_we1, a_full, a_empty;
  logic [31:0] a_rd_data, a_w0, a_w1, a_r1;
  logic [6:0]  a_addr0, a_addr1;
  logic [7:0]  a_count;
  logic [31:0] mem_a [128];

  dpram_fifo_ctrl #(.DATA_N(32), .SIZE(128)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_valid(a_wv), .wr_data(a_wd), .wr_ready(a_wr_ready),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_ready(a_rr),
    .ram_we0(a_we0), .ram_addr0(a_addr0), .ram_w0_data(a_w0),
    .ram_we1(a_we1), .ram_addr1(a_addr1), .ram_w1_data(a_w1), .ram_r1_data(a_r1),
    .count(a_count), .full(a_full), .empty(a_empty)
  );

  always @(posedge clk) begin
    if (a_we0) mem_a[a_addr0] <= a_w0;
    a_r1 <= mem_a[a_addr1];
  end

  // ---------------- instance B: SIZE=4 ----------------
  logic        b_wv = 1'b0, b_rr = 1'b0;
  logic [31:0] b_wd = '0;
  logic        b_wr_ready, b_rd_valid, b_we0, b_we1, b_full, b_empty;
  logic [31:0] b_rd_data, b_w0, b_w1, b_r1;
  logic [1:0]  b_addr0, b_addr1;
  logic [2:0]  b_count;
  logic [31:0] mem_b [4];

  dpram_fifo_ctrl #(.DATA_N(32), .SIZE(4)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_valid(b_wv), .wr_data(b_wd), .wr_ready(b_wr_ready),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_ready(b_rr),
    .ram_we0(b_we0), .ram_addr0(b_addr0), .ram_w0_data(b_w0),
    .ram_we1(b_we1), .ram_addr1(b_addr1), .ram_w1_data(b_w1), .ram_r1_data(b_r1),
    .count(b_count), .full(b_full), .empty(b_empty)
  );

  always @(posedge clk) begin
    if (b_we0) mem_b[b_addr0] <= b_w0;
    b_r1 <= mem_b[b_addr1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboards: inputs change at negedge, sampled at negedge+2 ----------------
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
    end else begin
      chk("a_count_model", 32'(a_count), 32'(q_a.size()));
      if (a_rd_valid && a_rr) begin
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL a_pop_empty: got pop of %0h expected no word", a_rd_data);
        end else begin
          if (a_rd_data !== q_a[0]) begin
            errors++;
            $display("FAIL a_order: got %0h expected %0h", a_rd_data, q_a[0]);
          end
          void'(q_a.pop_front());
        end
      end
      if (a_wv && a_wr_ready) q_a.push_back(a_wd);

      chk("b_count_model", 32'(b_count), 32'(q_b.size()));
      if (b_rd_valid && b_rr) begin
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL b_pop_empty: got pop of %0h expected no word", b_rd_data);
        end else begin
          if (b_rd_data !== q_b[0]) begin
            errors++;
            $display("FAIL b_order: got %0h expected %0h", b_rd_data, q_b[0]);
          end
          void'(q_b.pop_front());
        end
      end
      if (b_wv && b_wr_ready) q_b.push_back(b_wd);

      chk("a_ob_cnt_le2", 32'(u_a.ob_cnt_q <= 2'd2), 32'd1);
      chk("b_ob_cnt_le2", 32'(u_b.ob_cnt_q <= 2'd2), 32'd1);
      chk("a_addr_clash", 32'(a_we0 && u_a.issue && (a_addr0 == a_addr1)), 32'd0);
      chk("b_addr_clash", 32'(b_we0 && u_b.issue && (b_addr0 == b_addr1)), 32'd0);
    end
  end

  typedef struct {
    logic        wv;
    logic [31:0] wd;
    logic        rr;
    logic        rv;
    logic [31:0] rd;
    int          cnt;
    logic        emp;
    logic        wrdy;
    logic        we;
    int          a0;
    int          a1;
  } vec_t;

  vec_t tbl [12];
  int   acc, pushed, cyc;
  logic found;

  initial begin
    //           wv    wd       rr    rv    rd       cnt emp   wrdy  we    a0 a1
    tbl[0]  = '{1'b1, 32'hA5, 1'b1, 1'b0, 32'h00, 0, 1'b1, 1'b1, 1'b1, 0, 0};
    tbl[1]  = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1, 1'b0, 1'b1, 1'b0, 1, 0};
    tbl[2]  = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1, 1'b0, 1'b1, 1'b0, 1, 1};
    tbl[3]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'hA5, 1, 1'b0, 1'b1, 1'b0, 1, 1};
    tbl[4]  = '{1'b0, 32'h00, 1'b1, 1'b0, 32'hA5, 0, 1'b1, 1'b1, 1'b0, 1, 1};
    tbl[5]  = '{1'b1, 32'h22, 1'b0, 1'b0, 32'hA5, 0, 1'b1, 1'b1, 1'b1, 1, 1};
    tbl[6]  = '{1'b1, 32'h33, 1'b0, 1'b0, 32'hA5, 1, 1'b0, 1'b1, 1'b1, 2, 1};
    tbl[7]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'hA5, 2, 1'b0, 1'b1, 1'b0, 3, 2};
    tbl[8]  = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h22, 2, 1'b0, 1'b1, 1'b0, 3, 3};
    tbl[9]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h22, 2, 1'b0, 1'b1, 1'b0, 3, 3};
    tbl[10] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h33, 1, 1'b0, 1'b1, 1'b0, 3, 3};
    tbl[11] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h33, 0, 1'b1, 1'b1, 1'b0, 3, 3};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd_valid", 32'(a_rd_valid), 0);
    chk("rst_rd_data", a_rd_data, 0);
    chk("rst_wr_ready", 32'(a_wr_ready), 0);
    chk("rst_count", 32'(a_count), 0);
    chk("rst_full", 32'(a_full), 0);
    chk("rst_empty", 32'(a_empty), 1);
    chk("rst_b_wr_ready", 32'(b_wr_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cycle-by-cycle vectors: latency, hold of rd_data, buffer fill/drain
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a_wv = tbl[i].wv; a_wd = tbl[i].wd; a_rr = tbl[i].rr;
      #1;
      chk($sformatf("v%0d_rd_valid", i), 32'(a_rd_valid), 32'(tbl[i].rv));
      chk($sformatf("v%0d_rd_data", i), a_rd_data, tbl[i].rd);
      chk($sformatf("v%0d_count", i), 32'(a_count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_empty", i), 32'(a_empty), 32'(tbl[i].emp));
      chk($sformatf("v%0d_wr_ready", i), 32'(a_wr_ready), 32'(tbl[i].wrdy));
      chk($sformatf("v%0d_we0", i), 32'(a_we0), 32'(tbl[i].we));
      chk($sformatf("v%0d_addr0", i), 32'(a_addr0), 32'(tbl[i].a0));
      chk($sformatf("v%0d_addr1", i), 32'(a_addr1), 32'(tbl[i].a1));
    end

    // Streaming 300 words at full rate
    for (int c = 0; c < 306; c++) begin
      @(negedge clk);
      a_wv = (c < 300); a_wd = 32'(c); a_rr = 1'b1;
      #1;
      if (c < 300) chk("stream_wr_ready", 32'(a_wr_ready), 1);
      if (c >= 3 && c < 303) begin
        chk("stream_rd_valid", 32'(a_rd_valid), 1);
        chk("stream_rd_data", a_rd_data, 32'(c - 3));
      end
    end

    // Fill to capacity with no reads
    acc = 0;
    for (int c = 0; c < 140; c++) begin
      @(negedge clk);
      a_wv = 1'b1; a_wd = 32'h1000 + 32'(c); a_rr = 1'b0;
      #1;
      if (a_wr_ready) acc++;
    end
    @(negedge clk);
    a_wv = 1'b0;
    #1;
    chk("cap_accepted", 32'(acc), 130);
    chk("cap_full", 32'(a_full), 1);
    chk("cap_count", 32'(a_count), 130);
    @(negedge clk);
    a_rr = 1'b1;
    #1;
    chk("pop_full_wr_ready_same", 32'(a_wr_ready), 0);
    @(negedge clk);
    a_rr = 1'b0;
    #1;
    chk("pop_full_wr_ready_next", 32'(a_wr_ready), 1);
    chk("pop_full_count", 32'(a_count), 129);
    chk("pop_full_full", 32'(a_full), 0);
    for (int c = 0; c < 140; c++) begin
      @(negedge clk);
      a_rr = 1'b1;
    end
    #1;
    chk("drain_a_empty", 32'(a_empty), 1);

    // SIZE=4: address wrap under random backpressure
    pushed = 0; cyc = 0;
    while (pushed < 20 && cyc < 400) begin
      @(negedge clk);
      b_wv = 1'b1; b_wd = 32'hB000 + 32'(pushed); b_rr = 1'($urandom_range(0, 1));
      #1;
      if (b_wr_ready) begin
        chk("b_addr0_seq", 32'(b_addr0), 32'(pushed % 4));
        chk("b_we0", 32'(b_we0), 1);
        pushed++;
      end
      cyc++;
    end
    chk("b_push_done", 32'(pushed), 20);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      b_wv = 1'b0; b_rr = 1'b1;
    end
    #1;
    chk("drain_b_empty", 32'(b_empty), 1);

    // SIZE=4 capacity
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      b_wv = 1'b1; b_wd = 32'hC000 + 32'(c); b_rr = 1'b0;
      #1;
      if (b_wr_ready) acc++;
    end
    @(negedge clk);
    b_wv = 1'b0;
    #1;
    chk("b_cap_accepted", 32'(acc), 6);
    chk("b_cap_full", 32'(b_full), 1);
    chk("b_cap_count", 32'(b_count), 6);
    chk("b_cap_wr_ready", 32'(b_wr_ready), 0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      b_rr = 1'b1;
    end
    @(negedge clk);
    b_rr = 1'b0;

    // Asynchronous reset mid-cycle with 5 words held
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a_wv = 1'b1; a_wd = 32'hD000 + 32'(c); a_rr = 1'b0;
    end
    repeat (4) begin
      @(negedge clk);
      a_wv = 1'b0;
    end
    #1;
    chk("pre_rst_count", 32'(a_count), 5);
    @(negedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_valid", 32'(a_rd_valid), 0);
    chk("arst_count", 32'(a_count), 0);
    chk("arst_wr_ready", 32'(a_wr_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      a_wv = (i == 0); a_wd = 32'h11; a_rr = 1'b1;
      #1;
      if (a_rd_valid) begin
        found = 1'b1;
        chk("post_rst_first_word", a_rd_data, 32'h11);
      end
    end
    chk("post_rst_word_seen", 32'(found), 1);

    // Random traffic on both instances against the scoreboards
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      a_wv = 1'($urandom_range(0, 1)); a_wd = $urandom; a_rr = ($urandom_range(0, 3) != 0);
      b_wv = 1'($urandom_range(0, 1)); b_wd = $urandom; b_rr = 1'($urandom_range(0, 1));
    end
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      a_wv = 1'b0; b_wv = 1'b0; a_rr = 1'b1; b_rr = 1'b1;
    end
    #1;
    chk("rand_a_empty", 32'(a_empty), 1);
    chk("rand_b_empty", 32'(b_empty), 1);
    chk("rand_a_queue", 32'(q_a.size()), 0);
    chk("rand_b_queue", 32'(q_b.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
